trap_ctrl: RTL and testbench
============================

# trap_ctrl

Machine-mode trap-entry sequencer for the intirvx core. It performs the forward half of the trap protocol; `mret` in the CSR unit is the return half. It accepts synchronous exceptions from the pipeline and level interrupts from the platform, then flushes the pipeline. It writes `mepc`/`mcause`/`mtval`/`mstatus` through a write-request port into the CSR unit, then redirects fetch to the `mtvec` handler.

## Interface
Parameters:
- XLEN, 32, datapath width (core `xlen`)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; one clock; reset is synchronous and active-high
- exc_v  in  1  synchronous exception request, one-cycle pulse
- exc_cause  in  4  exception code (`mcause[3:0]`)
- exc_pc  in  XLEN  PC of faulting instruction
- exc_tval  in  XLEN  trap value
- int_pc  in  XLEN  PC of oldest non-retired instruction (interrupt `mepc`)
- irq_ext / irq_timer / irq_sw  in  1 each  level interrupt lines
- mstatus  in  XLEN  current `mstatus`
- mie  in  XLEN  current `mie`
- mtvec  in  XLEN  current `mtvec`
- mip  out  XLEN  registered pending bits: [11]=ext, [7]=timer, [3]=sw, others 0
- csr_we  out  1  CSR write request
- csr_wadr  out  12  CSR address (`csr_pkg` constants)
- csr_wdata  out  XLEN  write data
- csr_wack  in  1  write accepted this cycle
- flush  out  1  pipeline flush pulse
- target_v  out  1  redirect valid pulse
- target  out  XLEN  handler address
- busy  out  1  sequencer not in IDLE

## Operation
- `mip` register: sampled from the irq lines every cycle.
- Interrupt pending: `take_int = mstatus[3] & |(mip & mie)`.
- Interrupt priority: ext (11) > sw (3) > timer (7).
- Trap arbitration in IDLE:
  - `exc_v` wins over `take_int`.
  - Cause, epc, tval and the int/exc flag are latched into internal registers on entry.
  - Interrupt: epc = `int_pc`, tval = 0.
- `mcause` value: `{is_int, 27'b0, code}`.
- `mstatus` write data:
  - MPIE[7] = MIE[3].
  - MIE[3] = 0.
  - MPP[12:11] = 2'b11.
  - All other bits from `mstatus`, sampled at trap entry.
- Target address:
  - base = `{mtvec[XLEN-1:2], 2'b00}`.
  - Target is base + 4*code when `mtvec[1:0]==1` and the trap is an interrupt; otherwise base.
  - Sampled at REDIRECT.
- FSM states and transitions:
  - IDLE: on trap, go to FLUSH.
  - FLUSH: `flush`=1, then go to W_EPC.
  - W_EPC, W_CAUSE, W_TVAL, W_STATUS: `csr_we`=1 with the matching address and data. Advance when `csr_wack`=1; otherwise hold.
  - REDIRECT: `target_v`=1, then go to IDLE.
- Handshake rules:
  - `csr_wadr`/`csr_wdata` stay stable while `csr_we`=1 and `csr_wack`=0.
  - `csr_wack` while `csr_we`=0 is ignored.
- Events while busy:
  - `exc_v` is dropped, because the pipeline is being flushed.
  - Interrupts stay pending in `mip` and are re-evaluated in IDLE.
- Reset mid-sequence:
  - Go to IDLE and clear the latches.
  - CSR writes already acked are not undone.

## Timing
- Reset values: `mip`=0, `csr_we`=0, `csr_wadr`=0, `csr_wdata`=0, `flush`=0, `target_v`=0, `target`=0, `busy`=0.
- Trap sampled at edge E0. With `csr_wack` tied high:
  - cycle 1 = FLUSH.
  - cycles 2–5 = the four writes.
  - cycle 6 = `target_v`.
  - Back in IDLE at cycle 7.
- Minimum trap-to-trap spacing: 7 cycles.
- Each wack stall adds one cycle.
- `flush` and `target_v` are exactly one cycle wide.
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to `csr_we`/`flush`.
- IRQ-to-`mip` latency: 1 cycle. IRQ-to-FLUSH latency: 2 cycles minimum.
- `mie`/`mstatus` changes become visible to arbitration in the same cycle.

## Structure
- Add to `csr_pkg`:
  - `trap_state_e` enum.
  - Interrupt codes `IRQ_MSI=3`, `IRQ_MTI=7`, `IRQ_MEI=11`.
  - Bit-position constants `MSTATUS_MIE=3`, `MSTATUS_MPIE=7`.
- Reuse the existing `MEPC`/`MCAUSE`/`MTVAL`/`MSTATUS` address constants.
- Sub-module `trap_irq_prio`: combinational priority encoder, `mip & mie` → {valid, code[3:0]}.

## Test plan
- `exc_v`, cause=2, pc=0x100, tval=0xDEAD, `mtvec`=0x200, wack=1:
  - flush at cycle 1.
  - Writes in order: MEPC=0x100, MCAUSE=0x2, MTVAL=0xDEAD, MSTATUS with MIE=0 and MPIE=old MIE.
  - `target`=0x200 at cycle 6.
- `irq_timer`=1, `mie`[7]=1, MIE=1, `mtvec`=0x201 (vectored), `int_pc`=0x40:
  - MCAUSE=0x80000007, MEPC=0x40, MTVAL=0.
  - `target`=0x21C.
- All three irqs high with all enabled: cause code 11. Drop ext: the next trap gives 3.
- `exc_v` and enabled irq in the same cycle: exception taken. The interrupt is taken after the return to IDLE, once MIE has been re-enabled by the bench.
- `csr_wack` low for 3 cycles during W_CAUSE: address and data stable, and `target_v` is delayed by 3 cycles.
- `rst` asserted during W_TVAL: next cycle all outputs are 0 and `busy`=0. A following `exc_v` runs a clean full sequence.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR-unit definitions: CSR addresses, trap sequencer states,
// interrupt codes and mstatus/mip bit positions.
package csr_pkg;

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;
  localparam logic [11:0] MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    TRAP_IDLE     = 3'd0,
    TRAP_FLUSH    = 3'd1,
    TRAP_W_EPC    = 3'd2,
    TRAP_W_CAUSE  = 3'd3,
    TRAP_W_TVAL   = 3'd4,
    TRAP_W_STATUS = 3'd5,
    TRAP_REDIRECT = 3'd6
  } trap_state_e;

  // Machine interrupt cause codes; each equals its bit position in mip/mie.
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam int unsigned MIP_MSI = 3;
  localparam int unsigned MIP_MTI = 7;
  localparam int unsigned MIP_MEI = 11;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// Fixed-priority encoder over enabled pending interrupts: ext > sw > timer.
module trap_irq_prio
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pend,
  output logic            valid_c,
  output logic [3:0]      code_c
);

  // Only the three machine interrupt bits can be set, so the OR reduction is exact.
  always_comb begin
    valid_c = |pend;
    code_c  = 4'd0;
    if (pend[MIP_MEI]) begin
      code_c = IRQ_MEI;
    end else if (pend[MIP_MSI]) begin
      code_c = IRQ_MSI;
    end else if (pend[MIP_MTI]) begin
      code_c = IRQ_MTI;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry: arbitrates exceptions/interrupts, flushes, writes
// mepc/mcause/mtval/mstatus through the CSR write port, then redirects fetch.
module trap_ctrl
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_v,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [XLEN-1:0] int_pc,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_sw,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mip,
  output logic            csr_we,
  output logic [11:0]     csr_wadr,
  output logic [XLEN-1:0] csr_wdata,
  input  logic            csr_wack,
  output logic            flush,
  output logic            target_v,
  output logic [XLEN-1:0] target,
  output logic            busy
);

  localparam logic [2:0] S_IDLE     = 3'(TRAP_IDLE);
  localparam logic [2:0] S_FLUSH    = 3'(TRAP_FLUSH);
  localparam logic [2:0] S_W_EPC    = 3'(TRAP_W_EPC);
  localparam logic [2:0] S_W_CAUSE  = 3'(TRAP_W_CAUSE);
  localparam logic [2:0] S_W_TVAL   = 3'(TRAP_W_TVAL);
  localparam logic [2:0] S_W_STATUS = 3'(TRAP_W_STATUS);
  localparam logic [2:0] S_REDIRECT = 3'(TRAP_REDIRECT);

  logic [2:0]      state_q, state_d;
  logic            is_int_q, is_int_d;
  logic [3:0]      code_q, code_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] status_q, status_d;

  logic [XLEN-1:0] mip_d;
  logic [XLEN-1:0] pend_c;
  logic            irq_v_c;
  logic [3:0]      irq_code_c;
  logic            take_int_c;
  logic [XLEN-1:0] status_trap_c;
  logic            vectored_c;

  logic            csr_we_d;
  logic [11:0]     csr_wadr_d;
  logic [XLEN-1:0] csr_wdata_d;
  logic [XLEN-1:0] target_d;

  always_comb begin
    mip_d          = '0;
    mip_d[MIP_MEI] = irq_ext;
    mip_d[MIP_MTI] = irq_timer;
    mip_d[MIP_MSI] = irq_sw;
  end

  assign pend_c = mip & mie;

  trap_irq_prio #(.XLEN(XLEN)) u_prio (
    .pend    (pend_c),
    .valid_c (irq_v_c),
    .code_c  (irq_code_c)
  );

  assign take_int_c = mstatus[MSTATUS_MIE] & irq_v_c;

  // mstatus image written on trap entry: stack MIE into MPIE, disable, MPP=M.
  always_comb begin
    status_trap_c                                = mstatus;
    status_trap_c[MSTATUS_MPIE]                  = mstatus[MSTATUS_MIE];
    status_trap_c[MSTATUS_MIE]                   = 1'b0;
    status_trap_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // Next state and trap latches.
  always_comb begin
    state_d  = state_q;
    is_int_d = is_int_q;
    code_d   = code_q;
    epc_d    = epc_q;
    tval_d   = tval_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (exc_v) begin
          state_d  = S_FLUSH;
          is_int_d = 1'b0;
          code_d   = exc_cause;
          epc_d    = exc_pc;
          tval_d   = exc_tval;
          status_d = status_trap_c;
        end else if (take_int_c) begin
          state_d  = S_FLUSH;
          is_int_d = 1'b1;
          code_d   = irq_code_c;
          epc_d    = int_pc;
          tval_d   = '0;
          status_d = status_trap_c;
        end
      end
      S_FLUSH:    state_d = S_W_EPC;
      S_W_EPC:    if (csr_wack) state_d = S_W_CAUSE;
      S_W_CAUSE:  if (csr_wack) state_d = S_W_TVAL;
      S_W_TVAL:   if (csr_wack) state_d = S_W_STATUS;
      S_W_STATUS: if (csr_wack) state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign vectored_c = is_int_q & (mtvec[1:0] == 2'b01);

  // Output images for the upcoming state; registered below so every output is a flop.
  always_comb begin
    csr_we_d    = 1'b0;
    csr_wadr_d  = '0;
    csr_wdata_d = '0;
    target_d    = target;
    case (state_d)
      S_W_EPC: begin
        csr_we_d    = 1'b1;
        csr_wadr_d  = MEPC;
        csr_wdata_d = epc_d;
      end
      S_W_CAUSE: begin
        csr_we_d    = 1'b1;
        csr_wadr_d  = MCAUSE;
        csr_wdata_d = {is_int_d, {(XLEN-5){1'b0}}, code_d};
      end
      S_W_TVAL: begin
        csr_we_d    = 1'b1;
        csr_wadr_d  = MTVAL;
        csr_wdata_d = tval_d;
      end
      S_W_STATUS: begin
        csr_we_d    = 1'b1;
        csr_wadr_d  = MSTATUS;
        csr_wdata_d = status_d;
      end
      S_REDIRECT: begin
        target_d = {mtvec[XLEN-1:2], 2'b00}
                 + (vectored_c ? XLEN'({code_q, 2'b00}) : XLEN'(0));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_int_q  <= 1'b0;
      code_q    <= '0;
      epc_q     <= '0;
      tval_q    <= '0;
      status_q  <= '0;
      mip       <= '0;
      csr_we    <= 1'b0;
      csr_wadr  <= '0;
      csr_wdata <= '0;
      flush     <= 1'b0;
      target_v  <= 1'b0;
      target    <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_int_q  <= is_int_d;
      code_q    <= code_d;
      epc_q     <= epc_d;
      tval_q    <= tval_d;
      status_q  <= status_d;
      mip       <= mip_d;
      csr_we    <= csr_we_d;
      csr_wadr  <= csr_wadr_d;
      csr_wdata <= csr_wdata_d;
      flush     <= (state_d == S_FLUSH);
      target_v  <= (state_d == S_REDIRECT);
      target    <= target_d;
      busy      <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized traps
// compared against a behavioural model of the trap-entry rules.
module tb_trap_ctrl;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            exc_v;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_pc, exc_tval, int_pc;
  logic            irq_ext, irq_timer, irq_sw;
  logic [XLEN-1:0] mstatus, mie, mtvec;
  logic [XLEN-1:0] mip;
  logic            csr_we;
  logic [11:0]     csr_wadr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_wack;
  logic            flush, target_v, busy;
  logic [XLEN-1:0] target;

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .exc_v(exc_v), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .int_pc(int_pc), .irq_ext(irq_ext), .irq_timer(irq_timer),
    .irq_sw(irq_sw), .mstatus(mstatus), .mie(mie), .mtvec(mtvec), .mip(mip),
    .csr_we(csr_we), .csr_wadr(csr_wadr), .csr_wdata(csr_wdata), .csr_wack(csr_wack),
    .flush(flush), .target_v(target_v), .target(target), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observations of one trap sequence.
  logic [11:0] w_adr[$];
  logic [31:0] w_dat[$];
  int          flush_cnt, flush_cyc, tv_cnt, tv_cyc, idle_cyc;
  logic [31:0] tv_tgt;
  bit          stall_bad, timeout;

  // Expected values from the model.
  logic [11:0] ea[4];
  logic [31:0] ed[4];
  logic [31:0] etgt;

  // Trap-entry rules: write list and handler address.
  function automatic void model(input bit is_int, input logic [3:0] code,
                                input logic [31:0] epc, input logic [31:0] tval,
                                input logic [31:0] mst, input logic [31:0] mtv,
                                output logic [11:0] a[4], output logic [31:0] d[4],
                                output logic [31:0] tgt);
    a[0] = 12'h341; a[1] = 12'h342; a[2] = 12'h343; a[3] = 12'h300;
    d[0] = epc;
    d[1] = (is_int ? 32'h8000_0000 : 32'h0) + 32'(code);
    d[2] = is_int ? 32'h0 : tval;
    d[3] = (mst & ~32'h88) | (mst[3] ? 32'h80 : 32'h0) | 32'h1800;
    tgt  = (mtv & ~32'h3) + ((is_int && mtv[1:0] == 2'b01) ? 32'(code) * 4 : 32'h0);
  endfunction

  // Highest-priority enabled interrupt: {valid, code}.
  function automatic logic [4:0] prio_model(input bit e, input bit t, input bit s,
                                            input logic [31:0] en);
    if (e && en[11]) return {1'b1, 4'd11};
    if (s && en[3])  return {1'b1, 4'd3};
    if (t && en[7])  return {1'b1, 4'd7};
    return 5'd0;
  endfunction

  // Follow one trap sequence from the trigger edge, acking writes and
  // optionally stalling one address; cycle 1 is the first cycle after the edge.
  task automatic capture(input logic [11:0] stall_adr, input int stall_len,
                         input bit apply_after, input logic [2:0] irq_after,
                         input logic [31:0] mst_after);
    int          stalls;
    bit          in_stall;
    logic [11:0] pa;
    logic [31:0] pd;
    w_adr.delete(); w_dat.delete();
    flush_cnt = 0; flush_cyc = -1; tv_cnt = 0; tv_cyc = -1; idle_cyc = -1;
    tv_tgt = 'x; stall_bad = 0; timeout = 1; stalls = stall_len; in_stall = 0;
    pa = '0; pd = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      exc_v = 1'b0;
      if (flush) begin
        flush_cnt++;
        flush_cyc = cyc;
        if (apply_after) begin
          {irq_ext, irq_timer, irq_sw} = irq_after;
          mstatus = mst_after;
        end
      end
      if (target_v) begin
        tv_cnt++;
        tv_cyc = cyc;
        tv_tgt = target;
      end
      if (csr_we) begin
        if (in_stall && {csr_wadr, csr_wdata} !== {pa, pd}) stall_bad = 1;
        if (csr_wadr == stall_adr && stalls > 0) begin
          csr_wack = 1'b0;
          stalls--;
          in_stall = 1;
          pa = csr_wadr;
          pd = csr_wdata;
        end else begin
          csr_wack = 1'b1;
          in_stall = 0;
          w_adr.push_back(csr_wadr);
          w_dat.push_back(csr_wdata);
        end
      end else begin
        csr_wack = 1'($urandom);
      end
      if (!busy && flush_cnt > 0) begin
        idle_cyc = cyc;
        timeout = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({mip, csr_we, csr_wadr, csr_wdata, flush, target_v, target} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b adr=%h wdata=%h flush=%b tv=%b target=%h mip=%h, required all 0",
               csr_we, csr_wadr, csr_wdata, flush, target_v, target, mip);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_exception();
    mstatus = 32'h8; mie = '0; mtvec = 32'h200;
    model(1'b0, 4'd2, 32'h100, 32'hDEAD, 32'h8, 32'h200, ea, ed, etgt);
    @(negedge clk);
    exc_v = 1'b1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
    capture(12'hFFF, 0, 1'b0, 3'b000, 32'h0);
    checks++;
    if (timeout || flush_cyc !== 1 || flush_cnt !== 1) begin
      errors++;
      $display("FAIL exc_flush: cycle=%0d count=%0d timeout=%0b, required cycle 1 count 1", flush_cyc, flush_cnt, timeout);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= w_adr.size() || {w_adr[i], w_dat[i]} !== {ea[i], ed[i]}) begin
        errors++;
        $display("FAIL exc_write%0d: got %0d writes, required %h=%h", i, w_adr.size(), ea[i], ed[i]);
      end
    end
    checks++;
    if (tv_cyc !== 6 || tv_cnt !== 1 || tv_tgt !== etgt) begin
      errors++;
      $display("FAIL exc_target: cycle=%0d count=%0d target=%h, required cycle 6 count 1 target %h", tv_cyc, tv_cnt, tv_tgt, etgt);
    end
    checks++;
    if (idle_cyc !== 7) begin
      errors++;
      $display("FAIL exc_idle: got cycle %0d required 7", idle_cyc);
    end
  endtask

  task automatic test_irq_vectored();
    mstatus = 32'h8; mie = 32'h80; mtvec = 32'h201; int_pc = 32'h40;
    model(1'b1, 4'd7, 32'h40, 32'h0, 32'h8, 32'h201, ea, ed, etgt);
    @(negedge clk);
    irq_timer = 1'b1;
    @(negedge clk);
    checks++;
    if (mip !== 32'h80) begin
      errors++;
      $display("FAIL irq_mip: got %h required 00000080", mip);
    end
    capture(12'hFFF, 0, 1'b1, 3'b000, 32'h8);
    // Capture started one cycle after the IRQ edge, so FLUSH lands on its cycle 1.
    checks++;
    if (timeout || flush_cyc !== 1 || flush_cnt !== 1) begin
      errors++;
      $display("FAIL irq_flush: cycle=%0d count=%0d, required cycle 1 count 1", flush_cyc, flush_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= w_adr.size() || {w_adr[i], w_dat[i]} !== {ea[i], ed[i]}) begin
        errors++;
        $display("FAIL irq_write%0d: got %0d writes, required %h=%h", i, w_adr.size(), ea[i], ed[i]);
      end
    end
    checks++;
    if (tv_cyc !== 6 || tv_tgt !== 32'h21C) begin
      errors++;
      $display("FAIL irq_target: cycle=%0d target=%h, required cycle 6 target 0000021c", tv_cyc, tv_tgt);
    end
  endtask

  task automatic test_priority();
    mstatus = 32'h8; mie = 32'h888; mtvec = 32'h201;
    @(negedge clk);
    {irq_ext, irq_timer, irq_sw} = 3'b111;
    capture(12'hFFF, 0, 1'b1, 3'b011, 32'h0);
    checks++;
    if (w_dat.size() < 2 || w_dat[1] !== 32'h8000_000B || tv_tgt !== 32'h22C) begin
      errors++;
      $display("FAIL prio_ext: writes=%0d target=%h, required mcause 8000000b target 0000022c", w_dat.size(), tv_tgt);
    end
    @(negedge clk);
    mstatus = 32'h8;
    capture(12'hFFF, 0, 1'b1, 3'b000, 32'h8);
    checks++;
    if (w_dat.size() < 2 || w_dat[1] !== 32'h8000_0003 || tv_tgt !== 32'h20C || flush_cyc !== 1) begin
      errors++;
      $display("FAIL prio_sw: writes=%0d target=%h flush=%0d, required mcause 80000003 target 0000020c flush 1", w_dat.size(), tv_tgt, flush_cyc);
    end
  endtask

  task automatic test_exc_vs_int();
    mstatus = 32'h0; mie = 32'h80; mtvec = 32'h201; int_pc = 32'h500;
    irq_timer = 1'b1;
    repeat (2) @(negedge clk);
    model(1'b0, 4'd5, 32'h300, 32'h77, 32'h8, 32'h201, ea, ed, etgt);
    exc_v = 1'b1; exc_cause = 4'd5; exc_pc = 32'h300; exc_tval = 32'h77; mstatus = 32'h8;
    capture(12'hFFF, 0, 1'b1, 3'b010, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= w_adr.size() || {w_adr[i], w_dat[i]} !== {ea[i], ed[i]}) begin
        errors++;
        $display("FAIL both_exc_write%0d: got %0d writes, required %h=%h", i, w_adr.size(), ea[i], ed[i]);
      end
    end
    checks++;
    if (tv_tgt !== etgt) begin
      errors++;
      $display("FAIL both_exc_target: got %h required %h", tv_tgt, etgt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mip !== 32'h80) begin
      errors++;
      $display("FAIL both_pending: busy=%b mip=%h, required busy 0 mip 00000080", busy, mip);
    end
    model(1'b1, 4'd7, 32'h500, 32'h0, 32'h8, 32'h201, ea, ed, etgt);
    mstatus = 32'h8;
    capture(12'hFFF, 0, 1'b1, 3'b000, 32'h8);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= w_adr.size() || {w_adr[i], w_dat[i]} !== {ea[i], ed[i]}) begin
        errors++;
        $display("FAIL both_int_write%0d: got %0d writes, required %h=%h", i, w_adr.size(), ea[i], ed[i]);
      end
    end
    checks++;
    if (tv_tgt !== etgt || flush_cyc !== 1) begin
      errors++;
      $display("FAIL both_int_target: target=%h flush=%0d, required target %h flush 1", tv_tgt, flush_cyc, etgt);
    end
  endtask

  task automatic test_stall();
    mstatus = 32'h0; mie = '0; mtvec = 32'h1000;
    model(1'b0, 4'd13, 32'hABC0, 32'h1234, 32'h0, 32'h1000, ea, ed, etgt);
    @(negedge clk);
    exc_v = 1'b1; exc_cause = 4'd13; exc_pc = 32'hABC0; exc_tval = 32'h1234;
    capture(12'h342, 3, 1'b0, 3'b000, 32'h0);
    checks++;
    if (stall_bad) begin
      errors++;
      $display("FAIL stall_stable: address/data changed during stall, required stable");
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= w_adr.size() || {w_adr[i], w_dat[i]} !== {ea[i], ed[i]}) begin
        errors++;
        $display("FAIL stall_write%0d: got %0d writes, required %h=%h", i, w_adr.size(), ea[i], ed[i]);
      end
    end
    checks++;
    if (tv_cyc !== 9 || tv_cnt !== 1 || idle_cyc !== 10) begin
      errors++;
      $display("FAIL stall_timing: target_v cycle=%0d count=%0d idle=%0d, required 9 1 10", tv_cyc, tv_cnt, idle_cyc);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    mstatus = 32'h8; mie = '0; mtvec = 32'h400;
    @(negedge clk);
    exc_v = 1'b1; exc_cause = 4'd4; exc_pc = 32'h880; exc_tval = 32'h99;
    for (int cyc = 1; cyc <= 20 && !hit; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      exc_v = 1'b0;
      csr_wack = 1'b1;
      if (csr_we && csr_wadr == 12'h343) begin
        hit = 1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
    end
    checks++;
    if (!hit || {mip, csr_we, csr_wadr, csr_wdata, flush, target_v, target, busy} !== '0) begin
      errors++;
      $display("FAIL rst_mid: hit=%0b we=%b adr=%h wdata=%h flush=%b tv=%b target=%h busy=%b, required all 0",
               hit, csr_we, csr_wadr, csr_wdata, flush, target_v, target, busy);
    end
    model(1'b0, 4'd6, 32'h9A0, 32'h5, 32'h8, 32'h400, ea, ed, etgt);
    exc_v = 1'b1; exc_cause = 4'd6; exc_pc = 32'h9A0; exc_tval = 32'h5;
    capture(12'hFFF, 0, 1'b0, 3'b000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= w_adr.size() || {w_adr[i], w_dat[i]} !== {ea[i], ed[i]}) begin
        errors++;
        $display("FAIL rst_after_write%0d: got %0d writes, required %h=%h", i, w_adr.size(), ea[i], ed[i]);
      end
    end
    checks++;
    if (flush_cyc !== 1 || tv_cyc !== 6 || tv_tgt !== etgt) begin
      errors++;
      $display("FAIL rst_after_seq: flush=%0d tv=%0d target=%h, required 1 6 %h", flush_cyc, tv_cyc, tv_tgt, etgt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      bit          is_int;
      logic [2:0]  irqs;
      logic [4:0]  pr;
      logic [3:0]  code;
      logic [31:0] epc, tval, mst;
      is_int = 1'($urandom);
      mtvec  = $urandom;
      mie    = $urandom;
      @(negedge clk);
      if (is_int) begin
        irqs = 3'($urandom_range(1, 7));
        pr = prio_model(irqs[2], irqs[1], irqs[0], mie);
        if (!pr[4]) begin
          irqs = 3'b111;
          mie  = mie | 32'h800;
          pr   = prio_model(1'b1, 1'b1, 1'b1, mie);
        end
        code = pr[3:0]; mst = $urandom | 32'h8; epc = $urandom; tval = 32'h0;
        mstatus = mst; int_pc = epc;
        {irq_ext, irq_timer, irq_sw} = irqs;
      end else begin
        code = 4'($urandom); mst = $urandom; epc = $urandom; tval = $urandom;
        mstatus = mst;
        exc_v = 1'b1; exc_cause = code; exc_pc = epc; exc_tval = tval;
      end
      model(is_int, code, epc, tval, mst, mtvec, ea, ed, etgt);
      capture(12'hFFF, 0, 1'b1, 3'b000, mst);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (i >= w_adr.size() || {w_adr[i], w_dat[i]} !== {ea[i], ed[i]}) begin
          errors++;
          $display("FAIL rand%0d_write%0d: got %0d writes, required %h=%h", n, i, w_adr.size(), ea[i], ed[i]);
        end
      end
      checks++;
      if (tv_tgt !== etgt || tv_cyc !== flush_cyc + 5 || flush_cyc !== (is_int ? 2 : 1)) begin
        errors++;
        $display("FAIL rand%0d_target: target=%h tv=%0d flush=%0d, required target %h flush %0d tv flush+5",
                 n, tv_tgt, tv_cyc, flush_cyc, etgt, is_int ? 2 : 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; exc_v = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0; int_pc = '0;
    irq_ext = 1'b0; irq_timer = 1'b0; irq_sw = 1'b0;
    mstatus = '0; mie = '0; mtvec = '0; csr_wack = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    rst = 1'b0;
    test_exception();
    test_irq_vectored();
    test_priority();
    test_exc_vs_int();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
